decryption_key: RTL and testbench
=================================

# decryption_key

Computes the RSA private exponent d = e⁻¹ mod phi_n using the iterative extended Euclidean algorithm. It consumes the public exponent e produced by key generation and the shared phi_n, and returns d for the decryption datapath. The block uses the same level-start / held-done handshake as the other key blocks. A flag reports when e has no inverse, i.e. gcd(e, phi_n) ≠ 1.

## Interface
- WIDTH, 64, operand width of phi_n, e and d
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  reset, asynchronous and active-low
- phi_n  input  WIDTH  modulus; must be held stable while busy
- e  input  WIDTH  value to invert; must be held stable while busy
- start_compute  input  1  level request, sampled in IDLE
- d  output  WIDTH  inverse in the range [0, phi_n); reset value 0
- done_compute  output  1  result valid; reset value 0
- no_inverse  output  1  gcd ≠ 1, or phi_n == 0; valid with done_compute; reset value 0

## Operation
- States: IDLE, INIT, DIV, UPDATE, NORMALIZE, END.
- IDLE → INIT when start_compute = 1. While in IDLE, done_compute and no_inverse are held at 0.
- INIT: load r0 = phi_n, r1 = e, t0 = 0, t1 = 1. Go to DIV, or go to NORMALIZE if e == 0.
- DIV: pulse div_start for 1 cycle. Wait for div_done.
  - The divider produces q = r0 / r1 and rem = r0 mod r1.
  - It also produces tn = t0 − q·t1, accumulated MSB-first by Horner's rule: acc = 2·acc − q_i·t1.
- UPDATE: r0 ← r1, r1 ← rem, t0 ← t1, t1 ← tn.
  - Go to NORMALIZE if rem == 0; otherwise go back to DIV.
- NORMALIZE: gcd = r0.
  - If r0 ≠ 1 or phi_n == 0: no_inverse ← 1, d ← 0.
  - Otherwise: d ← t0 + phi_n if t0 < 0, else d ← t0.
  - Go to END.
- END: done_compute = 1, and d / no_inverse are held. Return to IDLE when start_compute = 0, which may happen in the first END cycle.
- Arithmetic:
  - r values are unsigned WIDTH bits.
  - t values and the accumulator are signed WIDTH+2 bits. |t| ≤ phi_n, so no overflow is possible.
- e ≥ phi_n is legal: the first division reduces it.
- e == 1 gives d = 1.
- If start_compute drops mid-computation, it is ignored. The computation finishes, done_compute is high for 1 cycle in END, then the block returns to IDLE.
- Reset mid-operation (reset_n low) asynchronously forces IDLE, clears all outputs, and aborts the divider.
- Input changes while busy are undefined; verification does not check them.

## Timing
- The divider takes exactly WIDTH cycles from div_start to div_done. Each Euclid iteration is WIDTH+2 cycles: DIV launch, WIDTH divider cycles, UPDATE.
- Start sampled in IDLE at edge N:
  - INIT at N+1.
  - With k divisions, done_compute rises at edge N+3+k·(WIDTH+2).
  - For e == 0, done_compute rises at edge N+3.
- d and no_inverse change only in NORMALIZE. They are stable for the whole time done_compute is high.
- No new request is accepted until the FSM has passed through IDLE.

## Configuration
- DECRYPTION_KEY_CYCLE_COUNT_EN defined:
  - Adds output cycle_count [15:0].
  - It clears on the IDLE→INIT transition, increments every cycle outside IDLE and END, and freezes in END.
  - Reset value 0.
- Not defined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared package rsa_pkg holds:
  - The state enum constants: IDLE, INIT, DIV, UPDATE, NORMALIZE, END.
  - RSA_WIDTH = 64.
  - The signed t-width constant RSA_WIDTH+2.
- One sub-module, euclid_divstep:
  - Sequential restoring divider that also accumulates tn.
  - Inputs: r0, r1, t0, t1, div_start.
  - Outputs: q, rem, tn, div_done.
  - One quotient bit per cycle, with the same clk / reset_n.

## Test plan
- phi_n=3120, e=17 (4 divisions) → d=2753, no_inverse=0, done_compute rises at N+3+4·66 = N+267.
- phi_n=40, e=7 → d=23. phi_n=40, e=1 → d=1. phi_n=40, e=47 → d=23.
- phi_n=60, e=6 → no_inverse=1, d=0. phi_n=60, e=0 → no_inverse=1 at N+3.
- Hold start_compute high for 10 cycles after done → done_compute, d and no_inverse stay stable. Drop start → IDLE next cycle, done_compute=0.
- Pulse start_compute for 1 cycle (3120/17) → done_compute high for exactly 1 cycle, d=2753.
- Assert reset_n low during the 2nd DIV of 3120/17 → outputs 0 immediately. Restart with phi_n=40, e=7 → d=23 with nominal latency.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared RSA key-block definitions: FSM state encoding and operand widths.
package rsa_pkg;

   localparam int RSA_WIDTH   = 64;
   localparam int RSA_T_WIDTH = RSA_WIDTH + 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INIT      = 3'd1,
      DIV       = 3'd2,
      UPDATE    = 3'd3,
      NORMALIZE = 3'd4,
      END       = 3'd5
   } state_t;

endpackage

// File: rtl/euclid_divstep.sv
// Restoring divider for one Euclid step: q = r0/r1, rem = r0 mod r1, tn = t0 - q*t1.
// One quotient bit per cycle; div_done is high exactly WIDTH cycles after div_start.
import rsa_pkg::*;

module euclid_divstep #(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [WIDTH-1:0]        r0,
   input  logic [WIDTH-1:0]        r1,
   input  logic signed [WIDTH+1:0] t0,
   input  logic signed [WIDTH+1:0] t1,
   input  logic                    div_start,
   output logic [WIDTH-1:0]        q,
   output logic [WIDTH-1:0]        rem,
   output logic signed [WIDTH+1:0] tn,
   output logic                    div_done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   logic [WIDTH-1:0]        p_q, dvd_q, quo_q;
   logic signed [WIDTH+1:0] acc_q;
   logic [CW-1:0]           cnt_q;
   logic                    busy_q;

   logic [WIDTH-1:0]        p_in, dvd_in, quo_in, p_nx;
   logic signed [WIDTH+1:0] acc_in, acc_nx;
   logic [WIDTH:0]          shifted, diff;
   logic                    ge, step_en;

   // The launch cycle already retires the first (MSB) quotient bit from the live inputs.
   always_comb begin
      p_in    = div_start ? '0 : p_q;
      dvd_in  = div_start ? r0 : dvd_q;
      quo_in  = div_start ? '0 : quo_q;
      acc_in  = div_start ? '0 : acc_q;
      shifted = {p_in, dvd_in[WIDTH-1]};
      diff    = shifted - {1'b0, r1};
      ge      = (shifted >= {1'b0, r1});
      p_nx    = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      acc_nx  = (acc_in <<< 1) - (ge ? t1 : '0);
      step_en = div_start || (busy_q && (cnt_q != CNT_LAST));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_q    <= '0;
         dvd_q  <= '0;
         quo_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         if (step_en) begin
            p_q   <= p_nx;
            dvd_q <= {dvd_in[WIDTH-2:0], 1'b0};
            quo_q <= {quo_in[WIDTH-2:0], ge};
            acc_q <= acc_nx;
         end
         if (div_start) begin
            cnt_q  <= CW'(1);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            if (cnt_q == CNT_LAST) busy_q <= 1'b0;
            else                   cnt_q  <= cnt_q + CW'(1);
         end
      end
   end

   assign q        = quo_q;
   assign rem      = p_q;
   assign tn       = t0 + acc_q;
   assign div_done = busy_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/decryption_key.sv
// RSA private exponent d = e^-1 mod phi_n via iterative extended Euclid.
// Optional DECRYPTION_KEY_CYCLE_COUNT_EN adds a 16-bit busy-cycle counter output.
import rsa_pkg::*;

module decryption_key #(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] phi_n,
   input  logic [WIDTH-1:0] e,
   input  logic             start_compute,
`ifdef DECRYPTION_KEY_CYCLE_COUNT_EN
   output logic [15:0]      cycle_count,
`endif
   output logic [WIDTH-1:0] d,
   output logic             done_compute,
   output logic             no_inverse
);

   // Handshake: start_compute is a level sampled only in IDLE; done_compute stays high in
   // END (d/no_inverse stable) until start_compute is low, then the block returns to IDLE.

   state_t state, next_state;

   logic [WIDTH-1:0]        r0_q, r1_q, q, rem;
   logic signed [WIDTH+1:0] t0_q, t1_q, tn, t0_fix;
   logic                    launched_q, div_start, div_done, no_inv_q;

   euclid_divstep #(.WIDTH(WIDTH)) u_divstep (
      .clk       (clk),
      .reset_n   (reset_n),
      .r0        (r0_q),
      .r1        (r1_q),
      .t0        (t0_q),
      .t1        (t1_q),
      .div_start (div_start),
      .q         (q),
      .rem       (rem),
      .tn        (tn),
      .div_done  (div_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (start_compute) next_state = INIT;
         INIT:      next_state = (e == '0) ? NORMALIZE : DIV;
         DIV:       if (div_done) next_state = UPDATE;
         UPDATE:    next_state = (rem == '0) ? NORMALIZE : DIV;
         NORMALIZE: next_state = END;
         END:       if (!start_compute) next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   always_comb begin
      div_start    = (state == DIV) && !launched_q;
      done_compute = (state == END);
      no_inverse   = (state == END) && no_inv_q;
   end

   assign t0_fix = t0_q + $signed({2'b00, phi_n});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r0_q       <= '0;
         r1_q       <= '0;
         t0_q       <= '0;
         t1_q       <= '0;
         launched_q <= 1'b0;
         d          <= '0;
         no_inv_q   <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               r0_q       <= phi_n;
               r1_q       <= e;
               t0_q       <= '0;
               t1_q       <= 'sd1;
               launched_q <= 1'b0;
            end
            DIV: if (div_start) launched_q <= 1'b1;
            UPDATE: begin
               r0_q       <= r1_q;
               r1_q       <= rem;
               t0_q       <= t1_q;
               t1_q       <= tn;
               launched_q <= 1'b0;
            end
            NORMALIZE: begin
               // r0 now holds gcd(phi_n, e); t0 is the Bezout coefficient of e.
               if ((r0_q != 'd1) || (phi_n == '0)) begin
                  no_inv_q <= 1'b1;
                  d        <= '0;
               end else begin
                  no_inv_q <= 1'b0;
                  d        <= (t0_q < 0) ? t0_fix[WIDTH-1:0] : t0_q[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DECRYPTION_KEY_CYCLE_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                      cycle_count <= '0;
      else if ((state == IDLE) && (next_state == INIT))  cycle_count <= '0;
      else if ((state != IDLE) && (state != END))        cycle_count <= cycle_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_decryption_key.sv
// Directed self-checking bench for decryption_key: extended-Euclid model, latency and handshake checks.
module tb_decryption_key;

   localparam int W = 64;
   localparam int ITER = W + 2;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] phi_n = '0;
   logic [W-1:0] e = '0;
   logic         start_compute = 1'b0;
   logic [W-1:0] d;
   logic         done_compute;
   logic         no_inverse;
`ifdef DECRYPTION_KEY_CYCLE_COUNT_EN
   logic [15:0]  cycle_count;
`endif

   int checks = 0;
   int failures = 0;

   logic [W-1:0] exp_d = '0;
   logic         exp_ni = 1'b0;

   decryption_key dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .phi_n         (phi_n),
      .e             (e),
      .start_compute (start_compute),
`ifdef DECRYPTION_KEY_CYCLE_COUNT_EN
      .cycle_count   (cycle_count),
`endif
      .d             (d),
      .done_compute  (done_compute),
      .no_inverse    (no_inverse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: textbook extended Euclid on plain integers, counting divisions.
   task automatic model(input longint phi, input longint ee,
                        output longint md, output bit mni, output int k);
      longint r0, r1, t0, t1, qq, tmp;
      r0 = phi; r1 = ee; t0 = 0; t1 = 1; k = 0;
      while (r1 != 0) begin
         qq = r0 / r1;
         tmp = r0 - qq * r1; r0 = r1; r1 = tmp;
         tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
         k++;
      end
      if (r0 != 1 || phi == 0) begin
         mni = 1'b1; md = 0;
      end else begin
         mni = 1'b0; md = (t0 < 0) ? t0 + phi : t0;
      end
   endtask

   // Compare process: whenever done is up, outputs must match the model; otherwise no_inverse is 0.
   always @(negedge clk) begin
      if (reset_n) begin
         if (done_compute) begin
            chk("d_vs_model", d, exp_d);
            chk("no_inverse_vs_model", W'(no_inverse), W'(exp_ni));
         end else begin
            chk("no_inverse_idle", W'(no_inverse), '0);
         end
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      start_compute = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Launch one computation; returns edges from the start-sampling edge N until done is seen.
   task automatic run_op(input logic [W-1:0] phi, input logic [W-1:0] ee, input int hold,
                         input bit pulse, output int cyc, output logic [W-1:0] got_d);
      longint md;
      bit     mni;
      int     k;
      bit     seen;
      model(longint'(phi), longint'(ee), md, mni, k);
      @(negedge clk);
      exp_d = W'(md);
      exp_ni = mni;
      phi_n = phi;
      e = ee;
      start_compute = 1'b1;
      @(posedge clk);
      cyc = 0;
      seen = 1'b0;
      got_d = '0;
      if (pulse) #1 start_compute = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done_compute) seen = 1'b1;
         else begin
            @(posedge clk);
            cyc++;
         end
      end
      if (!seen) begin
         chk("done_timeout", '0, 1);
      end else begin
         got_d = d;
         chk("latency", W'(cyc), W'(2 + k * ITER));
`ifdef DECRYPTION_KEY_CYCLE_COUNT_EN
         chk("cycle_count", W'(cycle_count), W'(2 + k * ITER));
`endif
         if (pulse) begin
            @(negedge clk);
            chk("done_one_cycle", W'(done_compute), '0);
         end else begin
            for (int i = 0; i < hold; i++) begin
               @(negedge clk);
               chk("done_held", W'(done_compute), 1);
            end
            start_compute = 1'b0;
            @(negedge clk);
            chk("done_drop", W'(done_compute), '0);
         end
      end
   endtask

   initial begin
      int           cyc;
      logic [W-1:0] got;
      longint       md;
      bit           mni;
      int           k;

      do_reset();
      #1;
      chk("reset_d", d, '0);
      chk("reset_done", W'(done_compute), '0);
      chk("reset_no_inverse", W'(no_inverse), '0);

      model(3120, 17, md, mni, k);
      chk("model_3120_17_d", W'(md), 2753);
      chk("model_3120_17_k", W'(k), 4);
      model(60, 6, md, mni, k);
      chk("model_60_6_ni", W'(mni), 1);

      run_op(3120, 17, 10, 1'b0, cyc, got);
      chk("lit_3120_17_d", got, 2753);
      chk("lit_3120_17_lat", W'(cyc), 266);

      run_op(40, 7, 0, 1'b0, cyc, got);
      chk("lit_40_7_d", got, 23);
      run_op(40, 1, 0, 1'b0, cyc, got);
      chk("lit_40_1_d", got, 1);
      run_op(40, 47, 0, 1'b0, cyc, got);
      chk("lit_40_47_d", got, 23);
      run_op(60, 6, 0, 1'b0, cyc, got);
      chk("lit_60_6_d", got, 0);
      run_op(60, 0, 2, 1'b0, cyc, got);
      chk("lit_60_0_lat", W'(cyc), 2);
      run_op(0, 5, 0, 1'b0, cyc, got);
      run_op(3120, 17, 0, 1'b1, cyc, got);
      chk("lit_pulse_d", got, 2753);

      // Reset during the second division of 3120/17 while d still holds 2753.
      @(negedge clk);
      phi_n = 3120;
      e = 17;
      start_compute = 1'b1;
      repeat (70) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      start_compute = 1'b0;
      #1;
      chk("abort_d", d, '0);
      chk("abort_done", W'(done_compute), '0);
      chk("abort_no_inverse", W'(no_inverse), '0);
`ifdef DECRYPTION_KEY_CYCLE_COUNT_EN
      chk("abort_cycle_count", W'(cycle_count), '0);
`endif
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      run_op(40, 7, 2, 1'b0, cyc, got);
      chk("restart_d", got, 23);
      chk("restart_lat", W'(cyc), 2 + 4 * ITER);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
